// File: rtl/uart_tx_serializer.sv
// UART transmit frame serializer: start bit, LSB-first data, optional parity, 1/2 stop bits.
// Optional line-break generation is compiled in with `define UART_TX_BREAK_EN (adds port break_req).
//
// state      | meaning
// IDLE       | line high, waiting for a word
// START      | start bit (TX low)
// DATA       | data bits, LSB first
// PARITY     | parity bit
// STOP       | one or two stop bits (TX high)
// BREAK      | break held, TX low (break build only)
// BRK_IDLE   | one idle bit period after break (break build only)
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  UCLK,
    input  logic                  reset,
    input  logic                  baud_tick,
    input  logic                  tx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  parity_en,
    input  logic                  parity_odd,
    input  logic                  two_stop,
`ifdef UART_TX_BREAK_EN
    input  logic                  break_req,
`endif
    output logic                  tx_ready,
    output logic                  tx_busy,
    output logic                  tx_done,
    output logic                  TX
);

    localparam int CW = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [2:0]    BIT_LAST  = 3'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK,
        S_BRK_IDLE
    } state_t;

    state_t                state_q;
    logic                  tx_q;
    logic                  done_q;
    logic [CW-1:0]         tick_q;
    logic [2:0]            bit_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  par_en_q;
    logic                  par_odd_q;
    logic                  two_stop_q;
    logic                  period_end;
    logic                  counting;

    assign period_end = baud_tick && (tick_q == TICK_LAST);
    // Only bit-timed states advance the tick counter; everything else holds it at 0.
    assign counting   = (state_q != S_IDLE) && (state_q != S_BREAK);

`ifdef UART_TX_BREAK_EN
    assign tx_ready = (state_q == S_IDLE) && !break_req;
`else
    assign tx_ready = (state_q == S_IDLE);
`endif
    assign tx_busy = (state_q != S_IDLE);
    assign tx_done = done_q;
    assign TX      = tx_q;

    always_ff @(posedge UCLK or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
            tick_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            two_stop_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (!counting) begin
                tick_q <= '0;
            end else if (baud_tick) begin
                tick_q <= period_end ? '0 : tick_q + 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    tx_q  <= 1'b1;
                    bit_q <= '0;
`ifdef UART_TX_BREAK_EN
                    if (break_req) begin
                        state_q <= S_BREAK;
                        tx_q    <= 1'b0;
                    end else
`endif
                    if (tx_valid) begin
                        shift_q    <= tx_data;
                        data_q     <= tx_data;
                        par_en_q   <= parity_en;
                        par_odd_q  <= parity_odd;
                        two_stop_q <= two_stop;
                        state_q    <= S_START;
                        tx_q       <= 1'b0;
                    end
                end
                S_START: begin
                    if (period_end) begin
                        state_q <= S_DATA;
                        tx_q    <= shift_q[0];
                        bit_q   <= '0;
                    end
                end
                S_DATA: begin
                    if (period_end) begin
                        if (bit_q == BIT_LAST) begin
                            bit_q <= '0;
                            if (par_en_q) begin
                                state_q <= S_PARITY;
                                tx_q    <= (^data_q) ^ par_odd_q;
                            end else begin
                                state_q <= S_STOP;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            shift_q <= shift_q >> 1;
                            tx_q    <= shift_q[1];
                        end
                    end
                end
                S_PARITY: begin
                    if (period_end) begin
                        state_q <= S_STOP;
                        tx_q    <= 1'b1;
                        bit_q   <= '0;
                    end
                end
                S_STOP: begin
                    if (period_end) begin
                        if (two_stop_q && (bit_q == 3'd0)) begin
                            bit_q <= 3'd1;
                        end else begin
                            state_q <= S_IDLE;
                            done_q  <= 1'b1;
                            bit_q   <= '0;
                        end
                    end
                end
`ifdef UART_TX_BREAK_EN
                S_BREAK: begin
                    tx_q <= 1'b0;
                    if (!break_req) begin
                        state_q <= S_BRK_IDLE;
                        tx_q    <= 1'b1;
                    end
                end
                S_BRK_IDLE: begin
                    tx_q <= 1'b1;
                    if (period_end) begin
                        state_q <= S_IDLE;
                    end
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: per-tick line levels compared against an expected
// bit list built from the frame format; break scenario included when UART_TX_BREAK_EN is defined.
module tb_uart_tx_serializer;

    localparam int OS = 16;

    logic       UCLK = 1'b0;
    logic       reset;
    logic       baud_tick;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       parity_en;
    logic       parity_odd;
    logic       two_stop;
    logic       tx_ready;
    logic       tx_busy;
    logic       tx_done;
    logic       TX;
`ifdef UART_TX_BREAK_EN
    logic       break_req = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int tick_div = 4;
    int tick_cnt = 0;

    uart_tx_serializer #(.DATA_WIDTH(8), .OVERSAMPLE(OS)) dut (
        .UCLK      (UCLK),
        .reset     (reset),
        .baud_tick (baud_tick),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .parity_en (parity_en),
        .parity_odd(parity_odd),
        .two_stop  (two_stop),
`ifdef UART_TX_BREAK_EN
        .break_req (break_req),
`endif
        .tx_ready  (tx_ready),
        .tx_busy   (tx_busy),
        .tx_done   (tx_done),
        .TX        (TX)
    );

    initial forever #5 UCLK = ~UCLK;

    // Strobe generator: one tick every tick_div clocks, updated just after the rising edge.
    initial begin
        baud_tick = 1'b0;
        forever begin
            @(posedge UCLK);
            #1;
            if (tick_cnt >= tick_div - 1) tick_cnt = 0;
            else tick_cnt = tick_cnt + 1;
            baud_tick = (tick_cnt == 0);
        end
    end

    task automatic wait_tick(output bit ok);
        int g = 0;
        do begin
            @(negedge UCLK);
            g++;
        end while (baud_tick !== 1'b1 && g < 64);
        ok = (baud_tick === 1'b1);
    endtask

    // Call at a falling edge. Offers one word, then checks every tick of the frame.
    task automatic run_frame(input logic [7:0] d, input logic pe, input logic po, input logic ts,
                             input bit hold, input bit immediate);
        bit exp_bits[$];
        int waited = 0;
        int bad;
        int ctl_bad = 0;
        bit ok;
        bit timed_out = 0;

        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
        if (pe) begin
            int ones = 0;
            for (int i = 0; i < 8; i++) ones += d[i];
            exp_bits.push_back(po ? ((ones % 2) == 0) : ((ones % 2) == 1));
        end
        exp_bits.push_back(1'b1);
        if (ts) exp_bits.push_back(1'b1);

        tx_data = d; parity_en = pe; parity_odd = po; two_stop = ts; tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && waited < 2000) begin
            @(negedge UCLK);
            waited++;
        end
        n_cmp++;
        if (waited >= 2000) begin
            n_bad++;
            $display("FAIL accept %02h: tx_ready never rose (waited %0d cycles)", d, waited);
            tx_valid = 1'b0;
            return;
        end
        if (immediate) begin
            n_cmp++;
            if (waited != 0) begin
                n_bad++;
                $display("FAIL b2b_accept %02h: waited %0d cycles, required 0", d, waited);
            end
        end

        @(posedge UCLK);
        #1;
        if (!hold) tx_valid = 1'b0;
        tx_data = 8'($urandom); parity_en = 1'($urandom);
        parity_odd = 1'($urandom); two_stop = 1'($urandom);
        n_cmp++;
        if ({TX, tx_busy, tx_ready} !== 3'b010) begin
            n_bad++;
            $display("FAIL start_latency %02h: TX/busy/ready=%b, required 010", d, {TX, tx_busy, tx_ready});
        end

        for (int b = 0; b < exp_bits.size(); b++) begin
            bad = 0;
            for (int k = 0; k < OS; k++) begin
                wait_tick(ok);
                if (!ok) timed_out = 1;
                if (TX !== exp_bits[b]) bad++;
                if (tx_ready !== 1'b0 || tx_done !== 1'b0 || tx_busy !== 1'b1) ctl_bad++;
            end
            n_cmp++;
            if (bad != 0) begin
                n_bad++;
                $display("FAIL frame %02h bit%0d: %0d of %0d ticks differ from required level %0d",
                         d, b, bad, OS, exp_bits[b]);
            end
        end
        n_cmp++;
        if (ctl_bad != 0 || timed_out) begin
            n_bad++;
            $display("FAIL frame %02h ctrl: %0d bad ready/done/busy samples, tick timeout=%0d, required 0",
                     d, ctl_bad, timed_out);
        end

        @(negedge UCLK);
        n_cmp++;
        if ({tx_done, tx_ready, tx_busy, TX} !== 4'b1101) begin
            n_bad++;
            $display("FAIL done %02h: done/ready/busy/TX=%b, required 1101", d,
                     {tx_done, tx_ready, tx_busy, TX});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
        parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0;
        #3;
        n_cmp++;
        if ({TX, tx_busy, tx_ready, tx_done} !== 4'b1010) begin
            n_bad++;
            $display("FAIL reset_state: TX/busy/ready/done=%b, required 1010", {TX, tx_busy, tx_ready, tx_done});
        end
        repeat (3) @(posedge UCLK);
        @(negedge UCLK);
        reset = 1'b0;
        repeat (5) @(negedge UCLK);
        n_cmp++;
        if ({TX, tx_busy, tx_ready, tx_done} !== 4'b1010) begin
            n_bad++;
            $display("FAIL idle_after_reset: TX/busy/ready/done=%b, required 1010", {TX, tx_busy, tx_ready, tx_done});
        end
    endtask

    task automatic test_basic();
        tick_div = 4;
        run_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge UCLK);
        n_cmp++;
        if (tx_done !== 1'b0) begin
            n_bad++;
            $display("FAIL done_width: tx_done=%b one cycle later, required 0", tx_done);
        end
    endtask

    task automatic test_parity();
        tick_div = 4;
        run_frame(8'hA3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame(8'hA3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_two_stop();
        tick_div = 4;
        run_frame(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        tick_div = 3;
        run_frame(8'h12, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_frame(8'h34, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_abort_reset();
        bit ok;
        int to = 0;
        tick_div = 4;
        repeat (3) @(negedge UCLK);
        tx_data = 8'h00; parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b0; tx_valid = 1'b1;
        @(posedge UCLK);
        #1;
        tx_valid = 1'b0;
        for (int k = 0; k < 70; k++) begin
            wait_tick(ok);
            if (!ok) to++;
        end
        n_cmp++;
        if (TX !== 1'b0 || tx_busy !== 1'b1 || to != 0) begin
            n_bad++;
            $display("FAIL abort_midframe: TX=%b busy=%b timeouts=%0d, required 0 1 0", TX, tx_busy, to);
        end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({TX, tx_busy, tx_ready, tx_done} !== 4'b1010) begin
            n_bad++;
            $display("FAIL abort_reset: TX/busy/ready/done=%b, required 1010", {TX, tx_busy, tx_ready, tx_done});
        end
        @(negedge UCLK);
        reset = 1'b0;
        @(negedge UCLK);
        run_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 10; n++) begin
            tick_div = $urandom_range(1, 5);
            run_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        end
        tx_valid = 1'b0;
        @(negedge UCLK);
    endtask

`ifdef UART_TX_BREAK_EN
    task automatic test_break();
        bit ok;
        int bad = 0;
        tick_div = 4;
        repeat (4) @(negedge UCLK);
        break_req = 1'b1;
        #1;
        n_cmp++;
        if (tx_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL break_ready: tx_ready=%b with break_req high, required 0", tx_ready);
        end
        @(posedge UCLK);
        #1;
        for (int k = 0; k < 200; k++) begin
            wait_tick(ok);
            if (!ok || TX !== 1'b0 || tx_ready !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL break_low: %0d of 200 ticks not TX=0/ready=0, required 0", bad);
        end
        break_req = 1'b0;
        @(posedge UCLK);
        #1;
        bad = 0;
        for (int k = 0; k < OS; k++) begin
            wait_tick(ok);
            if (!ok || TX !== 1'b1 || tx_ready !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL break_idle: %0d of %0d ticks not TX=1/ready=0, required 0", bad, OS);
        end
        @(negedge UCLK);
        n_cmp++;
        if (tx_ready !== 1'b1 || TX !== 1'b1) begin
            n_bad++;
            $display("FAIL break_release: ready=%b TX=%b, required 1 1", tx_ready, TX);
        end
        run_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_two_stop();
        test_back_to_back();
        test_abort_reset();
`ifdef UART_TX_BREAK_EN
        test_break();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
